// File: rtl/fpu_mem_pkg.sv
// Shared types and helpers for the FPU memory write path.
// The localparams describe the default buffer geometry.
package fpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_FIN
    } state_e;

    localparam int DEF_BUFFER_DEPTH = 512;
    localparam int DEF_COL_WIDTH    = 10;
    localparam int BADDR_BITS       = $clog2(DEF_BUFFER_DEPTH);
    localparam int WADDR_BITS       = $clog2(DEF_COL_WIDTH - 2);
    localparam int RADDR_BITS       = BADDR_BITS + WADDR_BITS;

    // The beat size is a power of two, so the ceiling divide becomes a shift.
    function automatic int unsigned beats_per_row(input int unsigned width,
                                                  input int unsigned lane_bits);
        return (width + (32'd1 << lane_bits) - 32'd1) >> lane_bits;
    endfunction

endpackage

// File: rtl/fpu_beat_packer.sv
// Assembles buffer bytes into one DRAM beat and tracks which lanes hold data.
// The lanes and strobes are emptied when the beat is accepted.
module fpu_beat_packer #(
    parameter  int BEAT_BYTES = 8,
    localparam int LANE_BITS  = $clog2(BEAT_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_i,
    input  logic [LANE_BITS-1:0]    lane_i,
    input  logic [7:0]              data_i,
    input  logic                    clear_i,
    output logic [8*BEAT_BYTES-1:0] wdata_o,
    output logic [BEAT_BYTES-1:0]   wstrb_o
);

    logic [8*BEAT_BYTES-1:0] wdata_q;
    logic [BEAT_BYTES-1:0]   wstrb_q;

    // NOTE: clocked state uses non-blocking assignments, so every register samples pre-edge values.
    // NOTE: the lane register is reset and cleared along with the strobes, so the
    // unfilled lanes of a partial beat go out as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (clear_i) begin
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cap_i) begin
            wdata_q[{lane_i, 3'b000} +: 8] <= data_i;
            wstrb_q[lane_i]                <= 1'b1;
        end
    end

    assign wdata_o = wdata_q;
    assign wstrb_o = wstrb_q;

endmodule

// File: rtl/fpu_write_burst_controller.sv
// Drains one column write buffer to DRAM as byte-packed beats, one row at a time.
// A row address register adds the stride once per row, so no multiplier is needed.
module fpu_write_burst_controller
    import fpu_mem_pkg::*;
#(
    parameter  int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter  int COL_WIDTH    = DEF_COL_WIDTH,
    parameter  int BEAT_BYTES   = 8,
    parameter  int NUM_BUFS     = 2,
    parameter  int ADDR_WIDTH   = 32,
    localparam int C_BITS       = $clog2(BUFFER_DEPTH),
    localparam int R_BITS       = $clog2(COL_WIDTH - 2),
    localparam int SEL_W        = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [SEL_W-1:0]        buf_sel_i,
    input  logic [ADDR_WIDTH-1:0]   base_address_i,
    input  logic [ADDR_WIDTH-1:0]   row_stride_i,
    input  logic [C_BITS:0]         width_i,
    input  logic [R_BITS:0]         height_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [SEL_W-1:0]        buf_rd_sel_o,
    output logic [C_BITS+R_BITS-1:0] buf_rd_addr_o,
    input  logic [7:0]              buf_rd_data_i,
    output logic                    dram_valid_o,
    input  logic                    dram_ready_i,
    output logic [ADDR_WIDTH-1:0]   dram_addr_o,
    output logic [8*BEAT_BYTES-1:0] dram_wdata_o,
    output logic [BEAT_BYTES-1:0]   dram_wstrb_o
);

    localparam int              LANE_BITS  = $clog2(BEAT_BYTES);
    localparam logic [C_BITS:0] MAX_WIDTH  = (C_BITS + 1)'(BUFFER_DEPTH);
    localparam logic [R_BITS:0] MAX_HEIGHT = (R_BITS + 1)'(COL_WIDTH - 2);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
    logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
    logic [C_BITS:0]         width_q, width_d;
    logic [R_BITS:0]         height_q, height_d;
    logic [C_BITS-1:0]       col_q, col_d;
    logic [R_BITS-1:0]       row_q, row_d;
    logic                    issued_q, issued_d;
    logic                    pend_q, pend_d;
    logic [LANE_BITS-1:0]    pend_lane_q, pend_lane_d;
    logic                    pend_last_q, pend_last_d;
    logic                    err_q, err_d;
    logic [C_BITS+R_BITS-1:0] rd_addr;

    logic              last_col, last_row, issue_last, last_beat_in_row, accept, cap;
    logic [C_BITS-1:0] beat_col;

    assign last_col   = ({1'b0, col_q} == (width_q - (C_BITS + 1)'(1)));
    assign last_row   = ({1'b0, row_q} == (height_q - (R_BITS + 1)'(1)));
    assign issue_last = (&col_q[LANE_BITS-1:0]) || last_col;
    assign last_beat_in_row =
        ((32'(col_q) >> LANE_BITS) == (beats_per_row(32'(width_q), LANE_BITS) - 32'd1));
    assign beat_col   = {col_q[C_BITS-1:LANE_BITS], {LANE_BITS{1'b0}}};
    assign accept     = (state_q == ST_SEND) && dram_ready_i;
    assign cap        = (state_q == ST_FETCH) && pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            row_addr_q  <= '0;
            stride_q    <= '0;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            issued_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_lane_q <= '0;
            pend_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            row_addr_q  <= row_addr_d;
            stride_q    <= stride_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            issued_q    <= issued_d;
            pend_q      <= pend_d;
            pend_lane_q <= pend_lane_d;
            pend_last_q <= pend_last_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets its default first, so no path infers a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        row_addr_d  = row_addr_q;
        stride_d    = stride_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        issued_d    = issued_q;
        pend_d      = 1'b0;
        pend_lane_d = pend_lane_q;
        pend_last_d = 1'b0;
        err_d       = 1'b0;
        rd_addr     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if ((width_i > MAX_WIDTH) || (height_i > MAX_HEIGHT)) begin
                        err_d = 1'b1;
                    end else if ((width_i == '0) || (height_i == '0)) begin
                        state_d = ST_FIN;
                    end else begin
                        sel_d      = buf_sel_i;
                        row_addr_d = base_address_i;
                        stride_d   = row_stride_i;
                        width_d    = width_i;
                        height_d   = height_i;
                        col_d      = '0;
                        row_d      = '0;
                        issued_d   = 1'b0;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // Reads are pipelined: one address out per cycle, its byte lands a cycle later.
                if (!issued_q) begin
                    rd_addr     = {col_q, row_q};
                    pend_d      = 1'b1;
                    pend_lane_d = col_q[LANE_BITS-1:0];
                    pend_last_d = issue_last;
                    if (issue_last) issued_d = 1'b1;
                    else            col_d    = col_q + C_BITS'(1);
                end
                if (pend_q && pend_last_q) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dram_ready_i) begin
                    issued_d = 1'b0;
                    state_d  = ST_FETCH;
                    if (!last_beat_in_row) begin
                        col_d = col_q + C_BITS'(1);
                    end else if (last_row) begin
                        state_d = ST_FIN;
                    end else begin
                        row_d      = row_q + R_BITS'(1);
                        col_d      = '0;
                        row_addr_d = row_addr_q + stride_q;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    fpu_beat_packer #(.BEAT_BYTES(BEAT_BYTES)) u_packer (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (cap),
        .lane_i  (pend_lane_q),
        .data_i  (buf_rd_data_i),
        .clear_i (accept),
        .wdata_o (dram_wdata_o),
        .wstrb_o (dram_wstrb_o)
    );

    assign busy_o        = (state_q == ST_FETCH) || (state_q == ST_SEND);
    assign done_o        = (state_q == ST_FIN);
    assign err_o         = err_q;
    assign buf_rd_sel_o  = sel_q;
    assign buf_rd_addr_o = rd_addr;
    assign dram_valid_o  = (state_q == ST_SEND);
    assign dram_addr_o   = row_addr_q + ADDR_WIDTH'(beat_col);

endmodule

// File: tb/tb_fpu_write_burst_controller.sv
// Directed bench for fpu_write_burst_controller: buffer model, DRAM sink and
// hand-derived beat expectations for the default geometry.
module tb_fpu_write_burst_controller;
    import fpu_mem_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [0:0]            buf_sel = '0;
    logic [31:0]           base_address = '0;
    logic [31:0]           row_stride = '0;
    logic [BADDR_BITS:0]   width = '0;
    logic [WADDR_BITS:0]   height = '0;
    logic                  busy, done, err;
    logic [0:0]            buf_rd_sel;
    logic [RADDR_BITS-1:0] buf_rd_addr;
    logic [7:0]            buf_rd_data = '0;
    logic                  dram_valid;
    logic                  dram_ready = 1'b0;
    logic [31:0]           dram_addr;
    logic [63:0]           dram_wdata;
    logic [7:0]            dram_wstrb;

    fpu_write_burst_controller dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .buf_sel_i      (buf_sel),
        .base_address_i (base_address),
        .row_stride_i   (row_stride),
        .width_i        (width),
        .height_i       (height),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .buf_rd_sel_o   (buf_rd_sel),
        .buf_rd_addr_o  (buf_rd_addr),
        .buf_rd_data_i  (buf_rd_data),
        .dram_valid_o   (dram_valid),
        .dram_ready_i   (dram_ready),
        .dram_addr_o    (dram_addr),
        .dram_wdata_o   (dram_wdata),
        .dram_wstrb_o   (dram_wstrb)
    );

    always #5 clk = ~clk;

    // Buffer contents indexed by {col,row}, one byte of read latency.
    logic [7:0] mem [2][1 << RADDR_BITS];
    always @(posedge clk) buf_rd_data <= mem[buf_rd_sel][buf_rd_addr];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } beat_t;

    beat_t beats[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    done_cnt = 0;
    int    err_cnt = 0;
    int    valid_cyc = 0;
    int    rdy_mode = 0;      // 0: follow ready_force, 1: random stalls
    logic  ready_force = 1'b0;
    int    stall_left = 0;
    logic  acc_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DRAM sink: ready is settled first, then a beat is logged if it will be accepted at the next posedge.
    always @(negedge clk) begin
        if (rdy_mode == 1) begin
            if (acc_prev)            stall_left = $urandom_range(0, 10);
            else if (stall_left > 0) stall_left--;
            dram_ready = (stall_left == 0);
        end else begin
            dram_ready = ready_force;
        end
        if (done)       done_cnt++;
        if (err)        err_cnt++;
        if (dram_valid) valid_cyc++;
        acc_prev = dram_valid && dram_ready;
        if (acc_prev) beats.push_back('{dram_addr, dram_wdata, dram_wstrb});
    end

    function automatic logic [63:0] exp_data(input int b, input int r, input int c0, input int n);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < n; j++) d[8*j +: 8] = mem[b][(c0 + j) * 8 + r];
        return d;
    endfunction

    task automatic do_start(input logic s, input logic [BADDR_BITS:0] w, input logic [WADDR_BITS:0] h,
                            input logic [31:0] base, input logic [31:0] stride);
        buf_sel      = s;
        width        = w;
        height       = h;
        base_address = base;
        row_stride   = stride;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done_cnt != c0), 64'd1);
    endtask

    task automatic check_beat(input string tag, input int i, input logic [31:0] a,
                              input logic [63:0] d, input logic [7:0] s);
        if (i < beats.size()) begin
            check($sformatf("%s_addr[%0d]", tag, i), 64'(beats[i].addr), 64'(a));
            check($sformatf("%s_data[%0d]", tag, i), beats[i].data, d);
            check($sformatf("%s_strb[%0d]", tag, i), 64'(beats[i].strb), 64'(s));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, e0, v0, n;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < (1 << RADDR_BITS); i++) mem[b][i] = 8'($urandom);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_valid", 64'(dram_valid), 64'd0);
        check("rst_addr",  64'(dram_addr), 64'd0);
        check("rst_wdata", dram_wdata, 64'd0);
        check("rst_wstrb", 64'(dram_wstrb), 64'd0);
        check("rst_rdaddr", 64'(buf_rd_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full 512x8 transfer with random ready stalls.
        rdy_mode = 1;
        beats.delete();
        d0 = done_cnt;
        do_start(1'b0, 10'd512, 4'd8, 32'h1000, 32'h200);
        wait_done(20000);
        repeat (2) @(negedge clk);
        check("big_count", 64'(beats.size()), 64'd512);
        check("big_done_once", 64'(done_cnt - d0), 64'd1);
        for (int i = 0; i < 512; i++)
            check_beat("big", i, 32'h1000 + 32'(i / 64) * 32'h200 + 32'(8 * (i % 64)),
                       exp_data(0, i / 64, 8 * (i % 64), 8), 8'hFF);

        // Partial beats: width 13, two rows.
        rdy_mode    = 0;
        ready_force = 1'b1;
        repeat (2) @(negedge clk);
        beats.delete();
        do_start(1'b0, 10'd13, 4'd2, 32'h0, 32'd16);
        wait_done(500);
        repeat (2) @(negedge clk);
        check("part_count", 64'(beats.size()), 64'd4);
        check_beat("part", 0, 32'h00, exp_data(0, 0, 0, 8), 8'hFF);
        check_beat("part", 1, 32'h08, exp_data(0, 0, 8, 5), 8'h1F);
        check_beat("part", 2, 32'h10, exp_data(0, 1, 0, 8), 8'hFF);
        check_beat("part", 3, 32'h18, exp_data(0, 1, 8, 5), 8'h1F);

        // Rejected starts: height 9, then width 513.
        e0 = err_cnt;
        v0 = valid_cyc;
        do_start(1'b0, 10'd8, 4'd9, 32'h0, 32'h0);
        check("err_h_pulse", 64'(err), 64'd1);
        check("err_h_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("err_h_single", 64'(err), 64'd0);
        do_start(1'b0, 10'd513, 4'd1, 32'h0, 32'h0);
        check("err_w_pulse", 64'(err), 64'd1);
        repeat (4) @(negedge clk);
        check("err_count", 64'(err_cnt - e0), 64'd2);
        check("err_no_valid", 64'(valid_cyc - v0), 64'd0);
        check("err_busy_low", 64'(busy), 64'd0);

        // Zero width: done with no DRAM traffic.
        d0 = done_cnt;
        v0 = valid_cyc;
        do_start(1'b0, 10'd0, 4'd3, 32'h0, 32'h0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("zero_no_valid", 64'(valid_cyc - v0), 64'd0);
        check("zero_done_once", 64'(done_cnt - d0), 64'd1);

        // Backpressure: beat held stable for 20 stalled cycles, second start ignored.
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        beats.delete();
        do_start(1'b0, 10'd16, 4'd1, 32'h40, 32'h0);
        n = 0;
        while (!dram_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 64'(dram_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stall_valid[%0d]", i), 64'(dram_valid), 64'd1);
            check($sformatf("stall_addr[%0d]", i), 64'(dram_addr), 64'h40);
            check($sformatf("stall_wdata[%0d]", i), dram_wdata, exp_data(0, 0, 0, 8));
            check($sformatf("stall_wstrb[%0d]", i), 64'(dram_wstrb), 64'hFF);
            if (i == 5) do_start(1'b1, 10'd4, 4'd1, 32'h9000, 32'h0);
            else        @(negedge clk);
        end
        ready_force = 1'b1;
        wait_done(200);
        repeat (30) @(negedge clk);
        check("stall_count", 64'(beats.size()), 64'd2);
        check_beat("stall", 0, 32'h40, exp_data(0, 0, 0, 8), 8'hFF);
        check_beat("stall", 1, 32'h48, exp_data(0, 0, 8, 8), 8'hFF);
        check("stall_idle", 64'(busy), 64'd0);

        // Reset after three beats, then a fresh transfer from buffer 1.
        beats.delete();
        d0 = done_cnt;
        do_start(1'b0, 10'd512, 4'd8, 32'h1000, 32'h200);
        n = 0;
        while (beats.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_three_beats", 64'(beats.size() >= 3), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(dram_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_wstrb", 64'(dram_wstrb), 64'd0);
        check("mid_rst_wdata", dram_wdata, 64'd0);
        check("mid_rst_addr", 64'(dram_addr), 64'd0);
        check("mid_rst_rdaddr", 64'(buf_rd_addr), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_no_done", 64'(done_cnt - d0), 64'd0);
        beats.delete();
        do_start(1'b1, 10'd9, 4'd1, 32'h2000, 32'h0);
        check("new_busy", 64'(busy), 64'd1);
        check("new_rdsel", 64'(buf_rd_sel), 64'd1);
        check("new_rdaddr0", 64'(buf_rd_addr), 64'h000);
        @(negedge clk);
        check("new_rdaddr1", 64'(buf_rd_addr), 64'h008);
        wait_done(200);
        repeat (2) @(negedge clk);
        check("new_count", 64'(beats.size()), 64'd2);
        check_beat("new", 0, 32'h2000, exp_data(1, 0, 0, 8), 8'hFF);
        check_beat("new", 1, 32'h2008, exp_data(1, 0, 8, 1), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
